// File: rtl/heavy_part_stage.sv
// heavy_part_stage: Elastic Sketch heavy-part bucket stage applying the vote+/vote-/lambda eviction rule.
// Optional macro HEAVY_FLAG_EN adds a heavy flag bit to each bucket entry and to out_data.
module heavy_part_stage #(
    parameter int KEY_W     = 32,
    parameter int CNT_W     = 32,
    parameter int ADDR_W    = 12,
    parameter int RD_LAT    = 2,
    parameter int LAMBDA_SH = 3,
    parameter int FIFO_AW   = 9,
`ifdef HEAVY_FLAG_EN
    localparam int FLG      = 1,
`else
    localparam int FLG      = 0,
`endif
    localparam int ENT_W    = FLG + KEY_W + 2*CNT_W,
    localparam int IN_W     = ADDR_W + KEY_W + CNT_W,
    localparam int OUT_W    = FLG + KEY_W + CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_wr,
    input  logic [IN_W-1:0]   in_data,
    output logic              in_alf,
    output logic [ADDR_W-1:0] ram_rdaddr,
    input  logic [ENT_W-1:0]  ram_rdvalue,
    output logic              ram_wren,
    output logic [ADDR_W-1:0] ram_wraddr,
    output logic [ENT_W-1:0]  ram_wrvalue,
    output logic              out_wr,
    output logic [OUT_W-1:0]  out_data,
    input  logic              out_alf,
    output logic [31:0]       evict_cnt
);
    localparam int TW = CNT_W + LAMBDA_SH + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, UPDATE} state_t;
    state_t state, state_nxt;

    logic [IN_W-1:0]    fifo_mem [2**FIFO_AW];
    logic [IN_W-1:0]    fifo_q;
    logic [FIFO_AW-1:0] wptr, rptr;
    logic [FIFO_AW:0]   fcount;
    logic               push, fifo_rd, fifo_empty, can_pop, ld_item, upd;
    logic [2:0]         wait_cnt;

    assign push       = in_wr & ~fcount[FIFO_AW];
    assign fifo_empty = (fcount == '0);
    assign in_alf     = fcount[FIFO_AW] | fcount[FIFO_AW-1];
    assign can_pop    = !fifo_empty && !out_alf;

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wptr] <= in_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr   <= '0;
            rptr   <= '0;
            fcount <= '0;
            fifo_q <= '0;
        end else begin
            if (push) wptr <= wptr + FIFO_AW'(1);
            if (fifo_rd) begin
                rptr   <= rptr + FIFO_AW'(1);
                fifo_q <= fifo_mem[rptr];
            end
            if (push && !fifo_rd)
                fcount <= fcount + (FIFO_AW+1)'(1);
            else if (!push && fifo_rd)
                fcount <= fcount - (FIFO_AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (can_pop) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (wait_cnt == 3'd1) state_nxt = UPDATE;
            UPDATE:  state_nxt = can_pop ? ISSUE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        fifo_rd = 1'b0;
        ld_item = 1'b0;
        upd     = 1'b0;
        case (state)
            IDLE:    fifo_rd = can_pop;
            ISSUE:   ld_item = 1'b1;
            UPDATE:  begin
                upd     = 1'b1;
                fifo_rd = can_pop;
            end
            default: ;
        endcase
    end

    logic [ADDR_W-1:0] it_addr;
    logic [KEY_W-1:0]  it_key, old_key, wr_key, o_key;
    logic [CNT_W-1:0]  it_cnt, old_pos, old_neg, sat_pos, sat_neg;
    logic [CNT_W-1:0]  wr_pos, wr_neg, o_cnt;
    logic [CNT_W:0]    sum_pos, sum_neg;
    logic              is_empty, is_match, is_evict, evict_hit, out_wr_n;
    logic [ENT_W-1:0]  wr_val_n;
    logic [OUT_W-1:0]  out_val_n;

    assign old_neg   = ram_rdvalue[0 +: CNT_W];
    assign old_pos   = ram_rdvalue[CNT_W +: CNT_W];
    assign old_key   = ram_rdvalue[2*CNT_W +: KEY_W];
    assign sum_pos   = {1'b0, old_pos} + {1'b0, it_cnt};
    assign sum_neg   = {1'b0, old_neg} + {1'b0, it_cnt};
    assign sat_pos   = sum_pos[CNT_W] ? '1 : sum_pos[CNT_W-1:0];
    assign sat_neg   = sum_neg[CNT_W] ? '1 : sum_neg[CNT_W-1:0];
    assign is_empty  = (old_pos == '0);
    assign is_match  = (old_key == it_key);
    // Widened so pos << LAMBDA_SH never loses high bits.
    assign is_evict  = TW'(sum_neg) >= (TW'(old_pos) << LAMBDA_SH);
    assign evict_hit = !is_empty && !is_match && is_evict;

    always_comb begin
        wr_key   = it_key;
        wr_pos   = it_cnt;
        wr_neg   = '0;
        o_key    = it_key;
        o_cnt    = it_cnt;
        out_wr_n = 1'b0;
        if (!is_empty) begin
            if (is_match) begin
                wr_key = old_key;
                wr_pos = sat_pos;
                wr_neg = old_neg;
            end else if (is_evict) begin
                o_key    = old_key;
                o_cnt    = old_pos;
                out_wr_n = 1'b1;
            end else begin
                wr_key   = old_key;
                wr_pos   = old_pos;
                wr_neg   = sat_neg;
                out_wr_n = 1'b1;
            end
        end
    end

`ifdef HEAVY_FLAG_EN
    logic old_flag, wr_flag, o_flag;
    assign old_flag  = ram_rdvalue[ENT_W-1];
    assign wr_flag   = !is_empty && (evict_hit ? 1'b1 : old_flag);
    assign o_flag    = evict_hit && old_flag;
    assign wr_val_n  = {wr_flag, wr_key, wr_pos, wr_neg};
    assign out_val_n = {o_flag, o_key, o_cnt};
`else
    assign wr_val_n  = {wr_key, wr_pos, wr_neg};
    assign out_val_n = {o_key, o_cnt};
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            it_addr     <= '0;
            it_key      <= '0;
            it_cnt      <= '0;
            wait_cnt    <= '0;
            ram_rdaddr  <= '0;
            ram_wren    <= 1'b0;
            ram_wraddr  <= '0;
            ram_wrvalue <= '0;
            out_wr      <= 1'b0;
            out_data    <= '0;
            evict_cnt   <= '0;
        end else begin
            ram_wren <= 1'b0;
            out_wr   <= 1'b0;
            if (ld_item) begin
                {it_addr, it_key, it_cnt} <= fifo_q;
                ram_rdaddr <= fifo_q[IN_W-1 -: ADDR_W];
                wait_cnt   <= 3'(RD_LAT);
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt - 3'd1;
            end
            if (upd) begin
                ram_wren    <= 1'b1;
                ram_wraddr  <= it_addr;
                ram_wrvalue <= wr_val_n;
                out_wr      <= out_wr_n;
                if (out_wr_n) out_data <= out_val_n;
                if (evict_hit) evict_cnt <= evict_cnt + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_heavy_part_stage.sv
// Directed bench for heavy_part_stage with a small latency-modelled bucket RAM.
module tb_heavy_part_stage;
    localparam int KEY_W  = 32;
    localparam int CNT_W  = 32;
    localparam int ADDR_W = 12;
    localparam int RD_LAT = 2;
`ifdef HEAVY_FLAG_EN
    localparam int FLG = 1;
`else
    localparam int FLG = 0;
`endif
    localparam int ENT_W = FLG + KEY_W + 2*CNT_W;
    localparam int IN_W  = ADDR_W + KEY_W + CNT_W;
    localparam int OUT_W = FLG + KEY_W + CNT_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_wr;
    logic [IN_W-1:0]   in_data;
    logic              in_alf;
    logic [ADDR_W-1:0] ram_rdaddr;
    logic [ENT_W-1:0]  ram_rdvalue;
    logic              ram_wren;
    logic [ADDR_W-1:0] ram_wraddr;
    logic [ENT_W-1:0]  ram_wrvalue;
    logic              out_wr;
    logic [OUT_W-1:0]  out_data;
    logic              out_alf;
    logic [31:0]       evict_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    heavy_part_stage dut (
        .clk(clk), .reset(reset), .in_wr(in_wr), .in_data(in_data), .in_alf(in_alf),
        .ram_rdaddr(ram_rdaddr), .ram_rdvalue(ram_rdvalue), .ram_wren(ram_wren),
        .ram_wraddr(ram_wraddr), .ram_wrvalue(ram_wrvalue), .out_wr(out_wr),
        .out_data(out_data), .out_alf(out_alf), .evict_cnt(evict_cnt)
    );

    logic [ENT_W-1:0] mem [64] = '{default: '0};
    logic [ENT_W-1:0] pipe [RD_LAT];
    logic             pl_en = 1'b0;
    logic [5:0]       pl_addr = '0;
    logic [ENT_W-1:0] pl_val = '0;

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_val;
        if (ram_wren) mem[ram_wraddr[5:0]] <= ram_wrvalue;
        pipe[0] <= mem[ram_rdaddr[5:0]];
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign ram_rdvalue = pipe[RD_LAT-1];

    function automatic logic [ENT_W-1:0] ent(input logic f, input logic [31:0] k,
                                             input logic [31:0] p, input logic [31:0] n);
        logic [KEY_W+2*CNT_W:0] full;
        full = {f, k, p, n};
        return full[ENT_W-1:0];
    endfunction

    function automatic logic [OUT_W-1:0] outv(input logic f, input logic [31:0] k,
                                              input logic [31:0] c);
        logic [KEY_W+CNT_W:0] full;
        full = {f, k, c};
        return full[OUT_W-1:0];
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [11:0] a, input logic [31:0] k, input logic [31:0] c);
        in_data = {a, k, c};
        in_wr   = 1'b1;
        @(negedge clk);
        in_wr   = 1'b0;
    endtask

    task automatic preload(input logic [5:0] a, input logic [ENT_W-1:0] v);
        pl_addr = a;
        pl_val  = v;
        pl_en   = 1'b1;
        @(negedge clk);
        pl_en   = 1'b0;
    endtask

    task automatic wait_wren(output int n);
        n = 0;
        while (ram_wren !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic expect_write(input string tag, input logic [11:0] a, input logic [ENT_W-1:0] v,
                                input logic ow, input logic [OUT_W-1:0] od, input int exp_lat);
        int n;
        wait_wren(n);
        check({tag, "_wren"}, ram_wren, 1'b1);
        if (exp_lat >= 0) check({tag, "_lat"}, n, exp_lat);
        check({tag, "_wraddr"}, ram_wraddr, a);
        check({tag, "_wrvalue"}, ram_wrvalue, v);
        check({tag, "_out_wr"}, out_wr, ow);
        if (ow) check({tag, "_out_data"}, out_data, od);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        reset   = 1'b0;
        in_wr   = 1'b0;
        in_data = '0;
        out_alf = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_wren", ram_wren, 1'b0);
        check("rst_out_wr", out_wr, 1'b0);
        check("rst_evict", evict_cnt, 32'd0);
        check("rst_in_alf", in_alf, 1'b0);
        check("rst_rdaddr", ram_rdaddr, 12'd0);
        reset = 1'b1;
        @(negedge clk);

        push(12'd5, 32'hA, 32'd4);
        expect_write("empty", 12'd5, ent(1'b0, 32'hA, 32'd4, 32'd0), 1'b0, '0, RD_LAT + 3);

        push(12'd5, 32'hA, 32'd3);
        expect_write("match", 12'd5, ent(1'b0, 32'hA, 32'd7, 32'd0), 1'b0, '0, RD_LAT + 3);

        push(12'd5, 32'hB, 32'd2);
        expect_write("noevict", 12'd5, ent(1'b0, 32'hA, 32'd7, 32'd2), 1'b1,
                     outv(1'b0, 32'hB, 32'd2), -1);
        check("noevict_cnt", evict_cnt, 32'd0);

        preload(6'd5, ent(1'b0, 32'hA, 32'd1, 32'd6));
        push(12'd5, 32'hB, 32'd2);
        expect_write("evict", 12'd5, ent(1'b1, 32'hB, 32'd2, 32'd0), 1'b1,
                     outv(1'b0, 32'hA, 32'd1), -1);
        check("evict_cnt", evict_cnt, 32'd1);

        preload(6'd6, ent(1'b0, 32'hA, 32'd1, 32'd5));
        push(12'd6, 32'hB, 32'd2);
        expect_write("justbelow", 12'd6, ent(1'b0, 32'hA, 32'd1, 32'd7), 1'b1,
                     outv(1'b0, 32'hB, 32'd2), -1);
        check("justbelow_cnt", evict_cnt, 32'd1);

        out_alf = 1'b1;
        push(12'd10, 32'hC, 32'd1);
        push(12'd11, 32'hD, 32'd2);
        push(12'd12, 32'hE, 32'd3);
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (ram_wren) cnt++;
        end
        check("bp_hold_wren", cnt, 0);
        out_alf = 1'b0;
        expect_write("bp1", 12'd10, ent(1'b0, 32'hC, 32'd1, 32'd0), 1'b0, '0, RD_LAT + 3);
        expect_write("bp2", 12'd11, ent(1'b0, 32'hD, 32'd2, 32'd0), 1'b0, '0, -1);
        expect_write("bp3", 12'd12, ent(1'b0, 32'hE, 32'd3, 32'd0), 1'b0, '0, -1);

        preload(6'd20, ent(1'b0, 32'h55, 32'hFFFF_FFFF, 32'd3));
        push(12'd20, 32'h55, 32'd5);
        expect_write("sat", 12'd20, ent(1'b0, 32'h55, 32'hFFFF_FFFF, 32'd3), 1'b0, '0, -1);

        push(12'd30, 32'h77, 32'd9);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_wren", ram_wren, 1'b0);
        check("midrst_in_alf", in_alf, 1'b0);
        check("midrst_evict", evict_cnt, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (ram_wren) cnt++;
        end
        check("midrst_nowrite", cnt, 0);
        check("midrst_mem30", mem[30], ent(1'b0, 32'h0, 32'h0, 32'h0));
        push(12'd31, 32'h78, 32'd6);
        expect_write("post_rst", 12'd31, ent(1'b0, 32'h78, 32'd6, 32'd0), 1'b0, '0, RD_LAT + 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
